// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue/writeback control around the two-stage multiplier.
// S1 tracks the op whose product is on mul_result; the output register
// holds the selected 32-bit half until the MEM/WB side takes it.
module mul_issue_ctrl (
  input  logic        mul_clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic [4:0]  in_dest,
  input  logic        flush,
  output logic        mul_signed,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_dest,
  output logic        busy
);

  localparam logic [1:0] OP_MUL_W   = 2'b00;
  localparam logic [1:0] OP_MULH_W  = 2'b01;
  localparam logic [1:0] OP_MULH_WU = 2'b10;

  logic        s1_valid;
  logic [1:0]  s1_op;
  logic [4:0]  s1_dest;
  logic [31:0] hold_x;
  logic [31:0] hold_y;
  logic        hold_signed;

  logic        out_free;
  logic        s1_adv;
  logic        accept;
  logic        in_signed;
  logic [31:0] sel_result;

  assign out_free  = !out_valid | out_ready;
  assign s1_adv    = s1_valid & out_free;
  assign in_ready  = !flush & (!s1_valid | out_free);
  assign accept    = in_valid & in_ready;
  assign in_signed = (in_op == OP_MULH_W);
  assign busy      = s1_valid | out_valid;

  // Operands go straight through on accept; otherwise the hold registers keep
  // the multiplier's free-running pipeline register fed with S1's operands.
  always_comb begin
    mul_x      = hold_x;
    mul_y      = hold_y;
    mul_signed = hold_signed;
    if (accept) begin
      mul_x      = in_src1;
      mul_y      = in_src2;
      mul_signed = in_signed;
    end
  end

  // High half for both mulh flavours; reserved op 11 falls into the low half.
  always_comb begin
    sel_result = mul_result[31:0];
    if ((s1_op == OP_MULH_W) || (s1_op == OP_MULH_WU))
      sel_result = mul_result[63:32];
    else if (s1_op == OP_MUL_W)
      sel_result = mul_result[31:0];
  end

  // S1 stage: reload on accept, empty when its op moves on with nothing behind it.
  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_op    <= 2'b00;
      s1_dest  <= 5'd0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= in_op;
      s1_dest  <= in_dest;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Operand hold registers, captured on every accept.
  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      hold_x      <= 32'd0;
      hold_y      <= 32'd0;
      hold_signed <= 1'b0;
    end else if (accept) begin
      hold_x      <= in_src1;
      hold_y      <= in_src2;
      hold_signed <= in_signed;
    end
  end

  // Output register: load from S1 when it advances, drain on out_ready.
  // Flush only drops the valid bit; payload is left as a don't-care.
  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_result <= 32'd0;
      out_dest   <= 5'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s1_adv) begin
      out_valid  <= 1'b1;
      out_result <= sel_result;
      out_dest   <= s1_dest;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
